lcg_stim_gen: RTL

//  Hardware stimulus source for the dual-simulator fuzz flow: regenerates the bench LCG sequence
//  (state = state*32'h41C64E6D + 32'h3039, mod 2^32) and packs it into IN_W-bit input vectors
//  for the DUT's in_flat port. Sits directly upstream of the DUT; emits one initial vector plus

---
 rtl/lcg_stim_pkg.sv | 16 +
 rtl/lcg_stim_gen_if.sv | 31 +++
 rtl/lcg_core.sv | 32 +++
 rtl/lcg_stim_gen.sv | 155 +++++++++++++++
 4 files changed

// File: rtl/lcg_stim_pkg.sv
// Shared definitions for the LCG stimulus generator.
//   LCG_MULT / LCG_INC : constants of the bench LCG (state = state*MULT + INC mod 2^32)
//   words_per_vec      : number of 32-bit LCG steps needed to fill a vector of w bits
//   lcg_state_e        : generator FSM states
package lcg_stim_pkg;

  localparam logic [31:0] LCG_MULT = 32'h41C64E6D;
  localparam logic [31:0] LCG_INC  = 32'h0000_3039;

  typedef enum logic [1:0] {IDLE, FILL, HOLD, DRAIN} lcg_state_e;

  function automatic int unsigned words_per_vec(input int unsigned w);
    return (w + 32'd31) / 32'd32;
  endfunction

endpackage

// File: rtl/lcg_stim_gen_if.sv
// Vector stream between the stimulus generator and its consumer.
//   vec_o       : current vector (in_flat image)
//   vec_valid_o : vec_o valid, held stable until accepted
//   vec_ready_i : consumer accept; transfer on posedge when valid & ready
//   vec_idx_o   : index of vec_o (0 = initial vector)
// master = generator side, slave = consumer side.
interface lcg_stim_gen_if #(
  parameter int unsigned IN_W  = 133,
  parameter int unsigned CNT_W = 32
);

  logic [IN_W-1:0]  vec_o;
  logic             vec_valid_o;
  logic             vec_ready_i;
  logic [CNT_W-1:0] vec_idx_o;

  modport master (
    output vec_o,
    output vec_valid_o,
    output vec_idx_o,
    input  vec_ready_i
  );

  modport slave (
    input  vec_o,
    input  vec_valid_o,
    input  vec_idx_o,
    output vec_ready_i
  );

endinterface

// File: rtl/lcg_core.sv
// 32-bit LCG state register.
//   clk, rst   : clock, asynchronous active-high reset (state -> 0)
//   load, seed : load seed into the state (has priority over step)
//   step       : advance the state by one LCG step
//   state_next : state*MULT + INC, i.e. the value a step would write
module lcg_core
  import lcg_stim_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        load,
  input  logic        step,
  input  logic [31:0] seed,
  output logic [31:0] state_next
);

  logic [31:0] state_q;

  // Product truncated to 32 bits; the add wraps mod 2^32.
  assign state_next = state_q * LCG_MULT + LCG_INC;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= '0;
    end else if (load) begin
      state_q <= seed;
    end else if (step) begin
      state_q <= state_next;
    end
  end

endmodule

// File: rtl/lcg_stim_gen.sv
// LCG stimulus generator: regenerates the bench LCG sequence and packs WORDS consecutive
// steps into each IN_W-bit vector. One initial vector plus cycles_i run vectors per start.
//   clk, rst    : clock, asynchronous active-high reset
//   start       : launches a run from IDLE (ignored while busy_o)
//   use_dflt_i  : 1 -> seed with SEED0, 0 -> seed with seed_i (sampled with start)
//   seed_i      : run seed
//   cycles_i    : run length; cycles_i + 1 vectors are emitted
//   vec_if      : vector stream (valid/ready, vector, index)
//   busy_o      : run in progress
//   done_o      : pulses the cycle after the last vector is accepted
module lcg_stim_gen
  import lcg_stim_pkg::*;
#(
  parameter int unsigned IN_W  = 133,
  parameter int unsigned CNT_W = 32,
  parameter logic [31:0] SEED0 = 32'd2016885264
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             use_dflt_i,
  input  logic [31:0]      seed_i,
  input  logic [CNT_W-1:0] cycles_i,
  lcg_stim_gen_if.master   vec_if,
  output logic             busy_o,
  output logic             done_o
);

  localparam int unsigned WORDS = words_per_vec(IN_W);
  localparam int unsigned PTR_W = (WORDS > 1) ? $clog2(WORDS) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(WORDS - 1);

  lcg_state_e       state_q, state_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  // One extra bit so cycles_i = 2^CNT_W-1 (2^CNT_W vectors) cannot overflow.
  logic [CNT_W:0]   gen_q, gen_d;
  logic [CNT_W-1:0] cycles_q, cycles_d;
  logic [IN_W-1:0]  stage_q, stage_d;
  logic [IN_W-1:0]  vec_q, vec_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] idx_q, idx_d;
  logic             done_q, done_d;

  logic             core_load, core_step;
  logic [31:0]      core_next;
  logic [31:0]      seed_sel;
  logic [CNT_W:0]   target;
  logic             accept;

  assign seed_sel = use_dflt_i ? SEED0 : seed_i;
  assign target   = {1'b0, cycles_q} + (CNT_W+1)'(1);
  assign accept   = valid_q & vec_if.vec_ready_i;

  lcg_core u_core (
    .clk        (clk),
    .rst        (rst),
    .load       (core_load),
    .step       (core_step),
    .seed       (seed_sel),
    .state_next (core_next)
  );

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    gen_d     = gen_q;
    cycles_d  = cycles_q;
    stage_d   = stage_q;
    vec_d     = vec_q;
    valid_d   = valid_q;
    idx_d     = idx_q;
    done_d    = 1'b0;
    core_load = 1'b0;
    core_step = 1'b0;

    if (accept) begin
      valid_d = 1'b0;
    end

    unique case (state_q)
      IDLE: begin
        if (start) begin
          core_load = 1'b1;
          ptr_d     = '0;
          gen_d     = '0;
          cycles_d  = cycles_i;
          state_d   = FILL;
        end
      end
      FILL: begin
        core_step = 1'b1;
        // Step k lands in word k; bits of the last word beyond IN_W are simply dropped.
        for (int unsigned b = 0; b < IN_W; b++) begin
          if (b / 32 == 32'(ptr_q)) begin
            stage_d[b] = core_next[5'(b % 32)];
          end
        end
        if (ptr_q == LAST_PTR) begin
          ptr_d   = '0;
          state_d = HOLD;
        end else begin
          ptr_d = ptr_q + PTR_W'(1);
        end
      end
      HOLD: begin
        // LCG is frozen here, so stream content never depends on ready timing.
        if (!valid_q || accept) begin
          vec_d   = stage_q;
          valid_d = 1'b1;
          idx_d   = gen_q[CNT_W-1:0];
          gen_d   = gen_q + (CNT_W+1)'(1);
          state_d = (gen_d < target) ? FILL : DRAIN;
        end
      end
      DRAIN: begin
        if (accept) begin
          done_d  = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      ptr_q    <= '0;
      gen_q    <= '0;
      cycles_q <= '0;
      stage_q  <= '0;
      vec_q    <= '0;
      valid_q  <= 1'b0;
      idx_q    <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      gen_q    <= gen_d;
      cycles_q <= cycles_d;
      stage_q  <= stage_d;
      vec_q    <= vec_d;
      valid_q  <= valid_d;
      idx_q    <= idx_d;
      done_q   <= done_d;
    end
  end

  assign vec_if.vec_o       = vec_q;
  assign vec_if.vec_valid_o = valid_q;
  assign vec_if.vec_idx_o   = idx_q;
  assign busy_o             = (state_q != IDLE);
  assign done_o             = done_q;

endmodule
